// File: rtl/planificador_destino.sv
// planificador_destino
// Destination scheduler for a five-floor lift (floors 0..4). It decides whether
// the car idles, moves up, moves down or serves the current floor. It also
// picks the target floor and emits one-cycle clear pulses back to the request
// latches.
//
// Ports
//   _clk_          rising-edge system clock
//   _reset_i       asynchronous active-low reset
//   solicitud_ps   latched request floor 0 (bit0 up/cabin, bit1 down)
//   solicitud_p1   latched request floor 1
//   solicitud_p2   latched request floor 2
//   solicitud_p3   latched request floor 3
//   solicitud_p4   latched request floor 4
//   piso_actual    Gray-coded car position (000,001,011,010,110 = 0..4)
//   sobrepeso      overweight flag, blocks leaving a served floor
//   servicio_fin   one-cycle pulse: door cycle at current floor finished
//   accion         00 parar, 01 subir, 10 bajar, 11 abrir (registered)
//   piso_destino   binary target floor (registered)
//   direccion      travel preference 00 none, 01 up, 10 down (registered)
//   clear_ps..p4   one-cycle request-clear pulses, at most one high (registered)
module planificador_destino (
  input  logic       _clk_,
  input  logic       _reset_i,
  input  logic [1:0] solicitud_ps,
  input  logic [1:0] solicitud_p1,
  input  logic [1:0] solicitud_p2,
  input  logic [1:0] solicitud_p3,
  input  logic [1:0] solicitud_p4,
  input  logic [2:0] piso_actual,
  input  logic       sobrepeso,
  input  logic       servicio_fin,
  output logic [1:0] accion,
  output logic [2:0] piso_destino,
  output logic [1:0] direccion,
  output logic       clear_ps,
  output logic       clear_p1,
  output logic       clear_p2,
  output logic       clear_p3,
  output logic       clear_p4
);

  localparam logic [1:0] ACC_PARAR = 2'b00;
  localparam logic [1:0] ACC_SUBIR = 2'b01;
  localparam logic [1:0] ACC_BAJAR = 2'b10;
  localparam logic [1:0] ACC_ABRIR = 2'b11;

  localparam logic [1:0] DIR_NINGUNA = 2'b00;
  localparam logic [1:0] DIR_SUBIR   = 2'b01;
  localparam logic [1:0] DIR_BAJAR   = 2'b10;

  typedef enum logic [1:0] {
    REPOSO,
    SUBIENDO,
    BAJANDO,
    SERVICIO
  } estado_t;

  // Decision taken this cycle; a separate block turns it into register updates.
  typedef enum logic [2:0] {
    M_CONGELAR,
    M_SERVICIO,
    M_PUERTA,
    M_SUBIR,
    M_BAJAR,
    M_REPOSO
  } movimiento_t;

  estado_t     estado_q, estado_d;
  movimiento_t movimiento;
  logic [1:0]  accion_q, accion_d;
  logic [2:0]  destino_q, destino_d;
  logic [1:0]  dir_q, dir_d;
  logic [4:0]  clear_q, clear_d;

  logic        piso_valido;
  logic [2:0]  piso_bin;
  logic [4:0]  pendiente;
  logic [4:0]  arriba;
  logic [4:0]  abajo;
  logic        hay_arriba;
  logic        hay_abajo;
  logic        pend_actual;
  logic        pedido_nuevo;
  logic        encontrado;
  logic [2:0]  prox_arriba;
  logic [2:0]  prox_abajo;

  assign pendiente = {|solicitud_p4, |solicitud_p3, |solicitud_p2,
                      |solicitud_p1, |solicitud_ps};

  always_comb begin
    piso_valido = 1'b1;
    piso_bin    = '0;
    case (piso_actual)
      3'b000:  piso_bin = 3'd0;
      3'b001:  piso_bin = 3'd1;
      3'b011:  piso_bin = 3'd2;
      3'b010:  piso_bin = 3'd3;
      3'b110:  piso_bin = 3'd4;
      default: piso_valido = 1'b0;
    endcase
  end

  // Pending floors strictly above/below the car, and the nearest of each.
  always_comb begin
    arriba      = '0;
    abajo       = '0;
    prox_arriba = piso_bin;
    prox_abajo  = piso_bin;
    encontrado  = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (3'(i) > piso_bin) arriba[i] = pendiente[i];
      if (3'(i) < piso_bin) abajo[i]  = pendiente[i];
      if (arriba[i] && !encontrado) begin
        prox_arriba = 3'(i);
        encontrado  = 1'b1;
      end
      if (abajo[i]) prox_abajo = 3'(i);
    end
  end

  assign hay_arriba  = |arriba;
  assign hay_abajo   = |abajo;
  assign pend_actual = pendiente[piso_bin];
  // A request still high during its own clear pulse is the latch lagging, not a new call.
  assign pedido_nuevo = pend_actual && !clear_q[piso_bin];

  always_comb begin
    movimiento = M_CONGELAR;
    if (piso_valido) begin
      case (estado_q)
        REPOSO: begin
          if (pend_actual)     movimiento = M_SERVICIO;
          else if (hay_arriba) movimiento = M_SUBIR;
          else if (hay_abajo)  movimiento = M_BAJAR;
          else                 movimiento = M_REPOSO;
        end
        SUBIENDO: begin
          if (pend_actual)     movimiento = M_SERVICIO;
          else if (hay_arriba) movimiento = M_SUBIR;
          else if (hay_abajo)  movimiento = M_BAJAR;
          else                 movimiento = M_REPOSO;
        end
        BAJANDO: begin
          if (pend_actual)     movimiento = M_SERVICIO;
          else if (hay_abajo)  movimiento = M_BAJAR;
          else if (hay_arriba) movimiento = M_SUBIR;
          else                 movimiento = M_REPOSO;
        end
        default: begin
          // A fresh call at this floor keeps the door cycle going instead of leaving.
          if (servicio_fin && !sobrepeso && !pedido_nuevo) begin
            if (dir_q == DIR_BAJAR && hay_abajo) movimiento = M_BAJAR;
            else if (hay_arriba)                 movimiento = M_SUBIR;
            else if (hay_abajo)                  movimiento = M_BAJAR;
            else                                 movimiento = M_REPOSO;
          end else begin
            movimiento = M_PUERTA;
          end
        end
      endcase
    end
  end

  always_comb begin
    estado_d  = estado_q;
    accion_d  = accion_q;
    destino_d = destino_q;
    dir_d     = dir_q;
    clear_d   = '0;
    case (movimiento)
      M_SERVICIO: begin
        estado_d           = SERVICIO;
        accion_d           = ACC_ABRIR;
        destino_d          = piso_bin;
        clear_d[piso_bin]  = 1'b1;
      end
      M_PUERTA: begin
        accion_d          = ACC_ABRIR;
        clear_d[piso_bin] = pedido_nuevo;
      end
      M_SUBIR: begin
        estado_d  = SUBIENDO;
        accion_d  = ACC_SUBIR;
        destino_d = prox_arriba;
        dir_d     = DIR_SUBIR;
      end
      M_BAJAR: begin
        estado_d  = BAJANDO;
        accion_d  = ACC_BAJAR;
        destino_d = prox_abajo;
        dir_d     = DIR_BAJAR;
      end
      M_REPOSO: begin
        estado_d = REPOSO;
        accion_d = ACC_PARAR;
        dir_d    = DIR_NINGUNA;
      end
      default: begin
        // Invalid position code: everything holds, motion command forced off.
        accion_d = ACC_PARAR;
      end
    endcase
  end

  always_ff @(posedge _clk_ or negedge _reset_i) begin
    if (!_reset_i) begin
      estado_q  <= REPOSO;
      accion_q  <= ACC_PARAR;
      destino_q <= '0;
      dir_q     <= DIR_NINGUNA;
      clear_q   <= '0;
    end else begin
      estado_q  <= estado_d;
      accion_q  <= accion_d;
      destino_q <= destino_d;
      dir_q     <= dir_d;
      clear_q   <= clear_d;
    end
  end

  assign accion       = accion_q;
  assign piso_destino = destino_q;
  assign direccion    = dir_q;
  assign clear_ps     = clear_q[0];
  assign clear_p1     = clear_q[1];
  assign clear_p2     = clear_q[2];
  assign clear_p3     = clear_q[3];
  assign clear_p4     = clear_q[4];

endmodule

// File: tb/tb_planificador_destino.sv
// Self-checking bench for planificador_destino. Each scenario task drives a
// sequence of steps; every step pushes its expected output word onto a
// scoreboard queue, which is popped and compared one cycle later.
// Output word layout: {accion, piso_destino, direccion, clear_p4..clear_ps}.
module tb_planificador_destino;

  localparam logic [2:0] G0 = 3'b000;
  localparam logic [2:0] G1 = 3'b001;
  localparam logic [2:0] G2 = 3'b011;
  localparam logic [2:0] G3 = 3'b010;
  localparam logic [2:0] G4 = 3'b110;

  logic       _clk_ = 1'b0;
  logic       _reset_i;
  logic [1:0] solicitud_ps, solicitud_p1, solicitud_p2, solicitud_p3, solicitud_p4;
  logic [2:0] piso_actual;
  logic       sobrepeso, servicio_fin;
  logic [1:0] accion;
  logic [2:0] piso_destino;
  logic [1:0] direccion;
  logic       clear_ps, clear_p1, clear_p2, clear_p3, clear_p4;

  planificador_destino dut (
    ._clk_        (_clk_),
    ._reset_i     (_reset_i),
    .solicitud_ps (solicitud_ps),
    .solicitud_p1 (solicitud_p1),
    .solicitud_p2 (solicitud_p2),
    .solicitud_p3 (solicitud_p3),
    .solicitud_p4 (solicitud_p4),
    .piso_actual  (piso_actual),
    .sobrepeso    (sobrepeso),
    .servicio_fin (servicio_fin),
    .accion       (accion),
    .piso_destino (piso_destino),
    .direccion    (direccion),
    .clear_ps     (clear_ps),
    .clear_p1     (clear_p1),
    .clear_p2     (clear_p2),
    .clear_p3     (clear_p3),
    .clear_p4     (clear_p4)
  );

  always #5 _clk_ = ~_clk_;

  typedef struct packed {
    logic [2:0]  piso;
    logic [9:0]  req;   // {p4, p3, p2, p1, ps}
    logic        sob;
    logic        fin;
    logic [11:0] esperado;
  } step_t;

  logic [11:0] exp_q[$];
  logic [11:0] obs;
  logic [11:0] e;
  int checks = 0;
  int errors = 0;

  assign obs = {accion, piso_destino, direccion,
                clear_p4, clear_p3, clear_p2, clear_p1, clear_ps};

  function automatic logic [11:0] ex(input logic [1:0] a, input logic [2:0] d,
                                     input logic [1:0] r, input logic [4:0] c);
    return {a, d, r, c};
  endfunction

  function automatic step_t paso(input logic [2:0] p, input logic [9:0] q,
                                 input logic sb, input logic fn, input logic [11:0] x);
    step_t s;
    s.piso = p; s.req = q; s.sob = sb; s.fin = fn; s.esperado = x;
    return s;
  endfunction

  task automatic drive(input step_t s);
    piso_actual = s.piso;
    {solicitud_p4, solicitud_p3, solicitud_p2, solicitud_p1, solicitud_ps} = s.req;
    sobrepeso    = s.sob;
    servicio_fin = s.fin;
    exp_q.push_back(s.esperado);
  endtask

  task automatic tick();
    @(posedge _clk_);
    #1;
  endtask

  task automatic zero_inputs();
    {solicitud_p4, solicitud_p3, solicitud_p2, solicitud_p1, solicitud_ps} = '0;
    piso_actual  = G0;
    sobrepeso    = 1'b0;
    servicio_fin = 1'b0;
  endtask

  task automatic do_reset();
    _reset_i = 1'b0;
    zero_inputs();
    #2;
    @(negedge _clk_);
    _reset_i = 1'b1;
  endtask

  task automatic test_reset();
    _reset_i = 1'b0;
    zero_inputs();
    #3;
    exp_q.push_back('0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_hold: got %h required %h", obs, e); end
    solicitud_p1 = 2'b01;
    exp_q.push_back('0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_clk: got %h required %h", obs, e); end
    @(negedge _clk_);
    solicitud_p1 = 2'b00;
    _reset_i = 1'b1;
    #1;
    exp_q.push_back('0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_release: got %h required %h", obs, e); end
    exp_q.push_back(ex(2'b00, 3'd0, 2'b00, 5'b00000));
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_idle: got %h required %h", obs, e); end
  endtask

  task automatic test_subida();
    step_t s[$];
    do_reset();
    s.push_back(paso(G0, 10'b00_01_00_00_00, 0, 0, ex(2'b01, 3'd3, 2'b01, 5'b00000)));
    s.push_back(paso(G1, 10'b00_01_00_00_00, 0, 0, ex(2'b01, 3'd3, 2'b01, 5'b00000)));
    s.push_back(paso(G2, 10'b00_01_00_00_00, 0, 0, ex(2'b01, 3'd3, 2'b01, 5'b00000)));
    s.push_back(paso(G3, 10'b00_01_00_00_00, 0, 0, ex(2'b11, 3'd3, 2'b01, 5'b01000)));
    s.push_back(paso(G3, 10'b00_00_00_00_00, 0, 0, ex(2'b11, 3'd3, 2'b01, 5'b00000)));
    s.push_back(paso(G3, 10'b00_00_00_00_00, 0, 1, ex(2'b00, 3'd3, 2'b00, 5'b00000)));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]); tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL subida[%0d]: got %h required %h", i, obs, e); end
    end
  endtask

  task automatic test_parada_colectiva();
    step_t s[$];
    do_reset();
    s.push_back(paso(G0, 10'b01_00_00_00_00, 0, 0, ex(2'b01, 3'd4, 2'b01, 5'b00000)));
    s.push_back(paso(G1, 10'b01_00_10_00_00, 0, 0, ex(2'b01, 3'd2, 2'b01, 5'b00000)));
    s.push_back(paso(G2, 10'b01_00_10_00_00, 0, 0, ex(2'b11, 3'd2, 2'b01, 5'b00100)));
    s.push_back(paso(G2, 10'b01_00_00_00_00, 0, 0, ex(2'b11, 3'd2, 2'b01, 5'b00000)));
    s.push_back(paso(G2, 10'b01_00_00_00_00, 0, 1, ex(2'b01, 3'd4, 2'b01, 5'b00000)));
    s.push_back(paso(G3, 10'b01_00_00_00_00, 0, 0, ex(2'b01, 3'd4, 2'b01, 5'b00000)));
    s.push_back(paso(G4, 10'b01_00_00_00_00, 0, 0, ex(2'b11, 3'd4, 2'b01, 5'b10000)));
    s.push_back(paso(G4, 10'b00_00_00_00_00, 0, 0, ex(2'b11, 3'd4, 2'b01, 5'b00000)));
    s.push_back(paso(G4, 10'b00_00_00_00_00, 0, 1, ex(2'b00, 3'd4, 2'b00, 5'b00000)));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]); tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL colectiva[%0d]: got %h required %h", i, obs, e); end
    end
  endtask

  task automatic test_ambas_direcciones();
    step_t s[$];
    do_reset();
    s.push_back(paso(G2, 10'b10_00_00_00_01, 0, 0, ex(2'b01, 3'd4, 2'b01, 5'b00000)));
    s.push_back(paso(G3, 10'b10_00_00_00_01, 0, 0, ex(2'b01, 3'd4, 2'b01, 5'b00000)));
    s.push_back(paso(G4, 10'b10_00_00_00_01, 0, 0, ex(2'b11, 3'd4, 2'b01, 5'b10000)));
    s.push_back(paso(G4, 10'b00_00_00_00_01, 0, 1, ex(2'b10, 3'd0, 2'b10, 5'b00000)));
    s.push_back(paso(G3, 10'b00_00_00_00_01, 0, 0, ex(2'b10, 3'd0, 2'b10, 5'b00000)));
    s.push_back(paso(G1, 10'b00_00_00_00_01, 0, 0, ex(2'b10, 3'd0, 2'b10, 5'b00000)));
    s.push_back(paso(G0, 10'b00_00_00_00_01, 0, 0, ex(2'b11, 3'd0, 2'b10, 5'b00001)));
    s.push_back(paso(G0, 10'b00_00_00_00_00, 0, 1, ex(2'b00, 3'd0, 2'b00, 5'b00000)));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]); tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL ambas[%0d]: got %h required %h", i, obs, e); end
    end
  endtask

  task automatic test_sobrepeso();
    step_t s[$];
    do_reset();
    s.push_back(paso(G1, 10'b00_00_00_01_00, 0, 0, ex(2'b11, 3'd1, 2'b00, 5'b00010)));
    s.push_back(paso(G1, 10'b00_00_00_00_00, 0, 0, ex(2'b11, 3'd1, 2'b00, 5'b00000)));
    s.push_back(paso(G1, 10'b00_00_00_00_00, 1, 1, ex(2'b11, 3'd1, 2'b00, 5'b00000)));
    s.push_back(paso(G1, 10'b00_00_00_10_00, 1, 0, ex(2'b11, 3'd1, 2'b00, 5'b00010)));
    s.push_back(paso(G1, 10'b00_00_00_10_00, 1, 0, ex(2'b11, 3'd1, 2'b00, 5'b00000)));
    s.push_back(paso(G1, 10'b00_00_00_00_00, 1, 0, ex(2'b11, 3'd1, 2'b00, 5'b00000)));
    s.push_back(paso(G1, 10'b00_01_00_00_00, 0, 1, ex(2'b01, 3'd3, 2'b01, 5'b00000)));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]); tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL sobrepeso[%0d]: got %h required %h", i, obs, e); end
    end
  endtask

  task automatic test_gray_invalido();
    step_t s[$];
    do_reset();
    s.push_back(paso(G1,     10'b00_01_00_00_00, 0, 0, ex(2'b01, 3'd3, 2'b01, 5'b00000)));
    s.push_back(paso(3'b111, 10'b00_01_00_00_00, 0, 0, ex(2'b00, 3'd3, 2'b01, 5'b00000)));
    s.push_back(paso(3'b101, 10'b00_01_00_00_00, 0, 0, ex(2'b00, 3'd3, 2'b01, 5'b00000)));
    s.push_back(paso(G2,     10'b00_01_00_00_00, 0, 0, ex(2'b01, 3'd3, 2'b01, 5'b00000)));
    s.push_back(paso(G3,     10'b00_01_00_00_00, 0, 0, ex(2'b11, 3'd3, 2'b01, 5'b01000)));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]); tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL gray[%0d]: got %h required %h", i, obs, e); end
    end
  endtask

  task automatic test_inversion();
    step_t s[$];
    do_reset();
    s.push_back(paso(G0, 10'b01_00_00_00_00, 0, 0, ex(2'b01, 3'd4, 2'b01, 5'b00000)));
    s.push_back(paso(G1, 10'b01_00_00_00_00, 1, 0, ex(2'b01, 3'd4, 2'b01, 5'b00000)));
    s.push_back(paso(G1, 10'b00_00_00_00_01, 0, 0, ex(2'b10, 3'd0, 2'b10, 5'b00000)));
    s.push_back(paso(G1, 10'b00_10_00_00_00, 0, 0, ex(2'b01, 3'd3, 2'b01, 5'b00000)));
    s.push_back(paso(G1, 10'b00_00_00_00_00, 0, 0, ex(2'b00, 3'd3, 2'b00, 5'b00000)));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]); tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL inversion[%0d]: got %h required %h", i, obs, e); end
    end
  endtask

  task automatic test_reset_servicio();
    do_reset();
    drive(paso(G3, 10'b00_01_00_00_00, 0, 0, ex(2'b11, 3'd3, 2'b00, 5'b01000)));
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_serv_entry: got %h required %h", obs, e); end
    _reset_i = 1'b0;
    #1;
    exp_q.push_back('0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_serv_async: got %h required %h", obs, e); end
    exp_q.push_back('0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_serv_held: got %h required %h", obs, e); end
    @(negedge _clk_);
    _reset_i = 1'b1;
    #1;
    exp_q.push_back('0);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_serv_release: got %h required %h", obs, e); end
    exp_q.push_back(ex(2'b11, 3'd3, 2'b00, 5'b01000));
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_serv_first_eval: got %h required %h", obs, e); end
    zero_inputs();
  endtask

  initial begin
    test_reset();
    test_subida();
    test_parada_colectiva();
    test_ambas_direcciones();
    test_sobrepeso();
    test_gray_invalido();
    test_inversion();
    test_reset_servicio();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
